// File: rtl/pc_update_unit.sv
// Program counter update with exception redirect, EPC capture and taken-branch counting.
// PCWriteEn is combinational; PC, EPC, AlignExc and TakenCount update on the next rising edge.
module pc_update_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        PCWriteCond,
   input  logic        BranchCond,
   input  logic [1:0]  PCSource,
   input  logic [31:0] ALUResult,
   input  logic [31:0] ALUOut,
   input  logic [25:0] JumpField,
   input  logic        ExcTrigger,
   output logic [31:0] PC,
   output logic [31:0] EPC,
   output logic        PCWriteEn,
   output logic        AlignExc,
   output logic [15:0] TakenCount
);

   logic [31:0] jump_target;
   logic [31:0] next_pc;
   logic        misaligned;
   logic        taken;

   assign PCWriteEn   = PCWrite | (PCWriteCond & BranchCond);
   assign jump_target = {PC[31:28], JumpField, 2'b00};

   always_comb begin
      next_pc = ALUResult;
      case (PCSource)
         2'b00:   next_pc = ALUResult;
         2'b01:   next_pc = ALUOut;
         2'b10:   next_pc = jump_target;
         2'b11:   next_pc = EPC;
         default: next_pc = ALUResult;
      endcase
   end

   assign misaligned = PCWriteEn & (next_pc[1:0] != 2'b00);
   // Only a branch that actually redirects the PC counts; exceptions and faults do not.
   assign taken = PCWriteCond & BranchCond & ~PCWrite & ~ExcTrigger & (next_pc[1:0] == 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PC         <= RESET_PC;
         EPC        <= 32'h0000_0000;
         AlignExc   <= 1'b0;
         TakenCount <= 16'h0000;
      end else begin
         AlignExc <= 1'b0;
         if (ExcTrigger) begin
            PC  <= EXC_VECTOR;
            EPC <= PC - 32'd4;
         end else if (misaligned) begin
            PC       <= EXC_VECTOR;
            EPC      <= PC - 32'd4;
            AlignExc <= 1'b1;
         end else if (PCWriteEn) begin
            PC <= next_pc;
         end
         if (taken && (TakenCount != 16'hFFFF))
            TakenCount <= TakenCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed plus randomized bench for pc_update_unit against an arithmetic reference model.
module tb_pc_update_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] EXC_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCWrite, PCWriteCond, BranchCond, ExcTrigger;
   logic [1:0]  PCSource;
   logic [31:0] ALUResult, ALUOut;
   logic [25:0] JumpField;
   logic [31:0] PC, EPC;
   logic        PCWriteEn, AlignExc;
   logic [15:0] TakenCount;

   int errors = 0;
   int checks = 0;

   // reference model state
   longint unsigned m_pc, m_epc;
   int              m_cnt;
   bit              m_al;

   always #5 clk = ~clk;

   pc_update_unit #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC)) dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .BranchCond(BranchCond), .PCSource(PCSource), .ALUResult(ALUResult),
      .ALUOut(ALUOut), .JumpField(JumpField), .ExcTrigger(ExcTrigger),
      .PC(PC), .EPC(EPC), .PCWriteEn(PCWriteEn), .AlignExc(AlignExc),
      .TakenCount(TakenCount)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_epc = 0; m_cnt = 0; m_al = 0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".PC"}, PC, m_pc[31:0]);
      check({tag, ".EPC"}, EPC, m_epc[31:0]);
      check({tag, ".AlignExc"}, {31'b0, AlignExc}, {31'b0, m_al});
      check({tag, ".TakenCount"}, {16'b0, TakenCount}, m_cnt);
   endtask

   // Drive one cycle of inputs, predict with plain arithmetic, clock, compare.
   task automatic step(input string tag, input bit w, input bit wc, input bit bc,
                       input int src, input longint unsigned ar, input longint unsigned ao,
                       input longint unsigned jf, input bit ex);
      longint unsigned tgt;
      bit en;
      PCWrite = w; PCWriteCond = wc; BranchCond = bc; PCSource = src[1:0];
      ALUResult = ar[31:0]; ALUOut = ao[31:0]; JumpField = jf[25:0]; ExcTrigger = ex;
      #1;
      en = w || (wc && bc);
      check({tag, ".PCWriteEn"}, {31'b0, PCWriteEn}, {31'b0, en});
      case (src)
         0: tgt = ar;
         1: tgt = ao;
         2: tgt = (m_pc / 32'h1000_0000) * 32'h1000_0000 + jf * 4;
         default: tgt = m_epc;
      endcase
      if (!ex && wc && bc && !w && (tgt % 4 == 0) && m_cnt < 65535) m_cnt++;
      if (ex) begin
         m_epc = (m_pc + 64'h1_0000_0000 - 4) % 64'h1_0000_0000; m_pc = EXC_PC; m_al = 0;
      end else if (en && (tgt % 4 != 0)) begin
         m_epc = (m_pc + 64'h1_0000_0000 - 4) % 64'h1_0000_0000; m_pc = EXC_PC; m_al = 1;
      end else begin
         if (en) m_pc = tgt;
         m_al = 0;
      end
      @(posedge clk);
      #1;
      check_state(tag);
   endtask

   initial begin
      reset = 1'b1;
      PCWrite = 0; PCWriteCond = 0; BranchCond = 0; PCSource = 0;
      ALUResult = 0; ALUOut = 0; JumpField = 0; ExcTrigger = 0;
      model_reset();
      #2;
      check_state("reset");
      #5 reset = 1'b0;

      // first write after reset
      step("pc4", 1, 0, 0, 0, 32'h4, 0, 0, 0);
      check("pc4.const", PC, 32'h4);
      // conditional branch not taken, then taken
      step("set40", 1, 0, 0, 0, 32'h40, 0, 0, 0);
      step("br_nt", 0, 1, 0, 1, 0, 32'h80, 0, 0);
      check("br_nt.const", PC, 32'h40);
      step("br_t", 0, 1, 1, 1, 0, 32'h80, 0, 0);
      check("br_t.cnt", {16'b0, TakenCount}, 32'd1);
      // jump keeps the upper nibble of PC
      step("set9", 1, 0, 0, 0, 32'h9000_0010, 0, 0, 0);
      step("jump", 1, 0, 0, 2, 0, 0, 26'h000_0040, 0);
      check("jump.const", PC, 32'h9000_0100);
      // misaligned write, AlignExc for one cycle only
      step("set20", 1, 0, 0, 0, 32'h20, 0, 0, 0);
      step("misal", 1, 0, 0, 0, 32'h22, 0, 0, 0);
      check("misal.epc", EPC, 32'h1C);
      step("hold", 0, 0, 0, 0, 32'h44, 0, 0, 0);
      // exception wins over a write, then return through EPC
      step("set30", 1, 0, 0, 0, 32'h30, 0, 0, 0);
      step("exc", 1, 0, 0, 0, 32'h34, 0, 0, 1);
      step("eret", 1, 0, 0, 3, 0, 0, 0, 0);
      check("eret.const", PC, 32'h2C);
      // EPC wraps below zero
      step("set0", 1, 0, 0, 0, 32'h0, 0, 0, 0);
      step("excwrap", 0, 0, 0, 0, 0, 0, 0, 1);
      check("excwrap.const", EPC, 32'hFFFF_FFFC);
      // misaligned taken branch does not count
      step("br_mis", 0, 1, 1, 1, 0, 32'h81, 0, 0);

      for (int i = 0; i < 400; i++) begin
         longint unsigned ar, ao;
         ar = $urandom; ao = $urandom;
         if ($urandom_range(3) != 0) ar = ar & 32'hFFFF_FFFC;
         if ($urandom_range(3) != 0) ao = ao & 32'hFFFF_FFFC;
         step("rand", $urandom_range(1), $urandom_range(1), $urandom_range(1),
              $urandom_range(3), ar, ao, $urandom & 32'h03FF_FFFF, $urandom_range(7) == 0);
      end

      // drive the counter into saturation
      PCWrite = 0; PCWriteCond = 1; BranchCond = 1; PCSource = 2'b01;
      ALUOut = 32'h80; ExcTrigger = 0;
      repeat (65540) @(posedge clk);
      #1;
      m_pc = 32'h80; m_cnt = 65535; m_al = 0;
      check("sat.cnt", {16'b0, TakenCount}, 32'h0000_FFFF);
      step("sat_more", 0, 1, 1, 1, 0, 32'h80, 0, 0);

      // asynchronous reset between edges, held across an edge with writes pending
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_state("arst");
      PCWrite = 1; ALUResult = 32'h44; ExcTrigger = 1;
      @(posedge clk);
      #1;
      check_state("arst_hold");
      #2 reset = 1'b0;
      step("post_rst", 1, 0, 0, 0, 32'h8, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
